// File: rtl/writeback_pkg.sv
// Shared pipeline definitions for the execute/writeback boundary:
// ex_wb field layout, writeback state encoding and flush default.
package writeback_pkg;

  localparam int XLEN = 32;
  localparam int EX_WB_W = 71;

  localparam int WB_RES_LSB = 0;
  localparam int WB_PC_LSB = 32;
  localparam int WB_RD_LSB = 64;
  localparam int WB_WE_BIT = 69;
  localparam int WB_BR_BIT = 70;

  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_FLUSH = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic br;
    logic we;
    logic [4:0] rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] res;
  } ex_wb_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two async read ports with write bypass,
// one sync write port, r0 hardwired to zero.
module regfile_2r1w
  import writeback_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr_a_i,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_ok;

  assign wr_ok = we_i && (waddr_i != 5'd0)
              && (int'(waddr_i) < NUM_REGS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = '0;
    if (raddr_a_i != 5'd0) begin
      if (wr_ok && raddr_a_i == waddr_i) begin
        rdata_a_o = wdata_i;
      end else if (int'(raddr_a_i) < NUM_REGS) begin
        rdata_a_o = regs_q[raddr_a_i];
      end
    end
  end

  always_comb begin
    rdata_b_o = '0;
    if (raddr_b_i != 5'd0) begin
      if (wr_ok && raddr_b_i == waddr_i) begin
        rdata_b_o = wdata_i;
      end else if (int'(raddr_b_i) < NUM_REGS) begin
        rdata_b_o = regs_q[raddr_b_i];
      end
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: retires execute words into the register file,
// raises a fetch redirect on taken branches and drops the shadow.
module writeback
  import writeback_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int NUM_REGS = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [EX_WB_W-1:0] ex_wb,
  input  logic               ex_wb_valid,
  input  logic [4:0]         rd_addr_a,
  input  logic [4:0]         rd_addr_b,
  output logic [XLEN-1:0]    rd_data_a,
  output logic [XLEN-1:0]    rd_data_b,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               flushing,
  output logic [XLEN-1:0]    retired_count
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  ex_wb_t          w;
  wb_state_e       state_q;
  logic [2:0]      fcnt_q;
  logic            redir_v_q;
  logic [XLEN-1:0] redir_pc_q;
  logic [XLEN-1:0] retired_q;
  logic [XLEN-1:0] retired_d;
  logic            retire;
  logic            rf_we;

  assign w = ex_wb_t'(ex_wb);
  assign retire = ex_wb_valid && (state_q == ST_RUN);
  assign rf_we = retire && w.we;
  assign retired_d = retire ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      fcnt_q     <= '0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
      retired_q  <= '0;
    end else begin
      retired_q <= retired_d;
      redir_v_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (retire && w.br) begin
            redir_v_q  <= 1'b1;
            redir_pc_q <= w.pc;
            fcnt_q     <= FLUSH_INIT;
            state_q    <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // stalls hold the counter; only consumed words drain it
          if (ex_wb_valid) begin
            fcnt_q <= fcnt_q - 3'd1;
            if (fcnt_q == 3'd1) begin
              state_q <= ST_RUN;
            end
          end
        end
      endcase
    end
  end

  regfile_2r1w #(
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clock     (clock),
    .reset_n   (reset_n),
    .we_i      (rf_we),
    .waddr_i   (w.rd),
    .wdata_i   (w.res),
    .raddr_a_i (rd_addr_a),
    .raddr_b_i (rd_addr_b),
    .rdata_a_o (rd_data_a),
    .rdata_b_o (rd_data_b)
  );

  assign redirect_valid = redir_v_q;
  assign redirect_pc    = redir_pc_q;
  assign flushing       = (state_q == ST_FLUSH);
  assign retired_count  = retired_q;

endmodule

// File: tb/tb_writeback.sv
// Randomized bench for writeback against an abstract retire model
// (register array, flush budget, retire counter).
module tb_writeback;

  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [70:0] ex_wb = '0;
  logic        ex_wb_valid = 1'b0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flushing;
  logic [31:0] retired_count;

  writeback #(
    .FLUSH_CYCLES (FC),
    .NUM_REGS     (32)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ex_wb          (ex_wb),
    .ex_wb_valid    (ex_wb_valid),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .rd_data_a      (rd_data_a),
    .rd_data_b      (rd_data_b),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flushing       (flushing),
    .retired_count  (retired_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails = 0;

  logic [31:0] m_regs [32];
  int          m_left;
  logic        m_rv;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [70:0] mk(input logic br,
                                     input logic we,
                                     input logic [4:0] rd,
                                     input logic [31:0] pc,
                                     input logic [31:0] res);
    return {br, we, rd, pc, res};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_left = 0;
    m_rv = 1'b0;
    m_pc = '0;
    m_cnt = '0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                         input logic wr,
                                         input logic [70:0] w);
    if (a == 5'd0) return '0;
    if (wr && a == w[68:64]) return w[31:0];
    return m_regs[a];
  endfunction

  task automatic check_outs();
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
    chk("redirect_pc", redirect_pc, m_pc);
    chk("flushing", {31'd0, flushing}, {31'd0, m_left != 0});
    chk("retired_count", retired_count, m_cnt);
  endtask

  task automatic step(input logic v, input logic [70:0] w,
                      input logic [4:0] a, input logic [4:0] b);
    logic wr;
    @(negedge clock);
    ex_wb = w;
    ex_wb_valid = v;
    rd_addr_a = a;
    rd_addr_b = b;
    #1;
    wr = v && (m_left == 0) && w[69] && (w[68:64] != 5'd0);
    chk("rd_a", rd_data_a, exp_rd(a, wr, w));
    chk("rd_b", rd_data_b, exp_rd(b, wr, w));
    @(posedge clock);
    m_rv = 1'b0;
    if (v) begin
      if (m_left == 0) begin
        m_cnt = m_cnt + 32'd1;
        if (wr) m_regs[w[68:64]] = w[31:0];
        if (w[70]) begin
          m_rv = 1'b1;
          m_pc = w[63:32];
          m_left = FC;
        end
      end else begin
        m_left = m_left - 1;
      end
    end
    #1;
    check_outs();
  endtask

  logic [31:0] c0;
  logic [70:0] rw;
  logic [4:0]  ra;
  logic [4:0]  rb;

  initial begin
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outs();
    chk("reset_rd_a", rd_data_a, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // write then read r5, bypass same cycle
    step(1, mk(0, 1, 5, 32'h0, 32'h0000ABCD), 5, 0);
    step(0, mk(0, 1, 5, 32'h0, 32'h1234), 5, 5);
    step(1, mk(0, 0, 7, 32'h0, 32'h5555), 5, 7);

    // r0 stays zero
    c0 = m_cnt;
    step(1, mk(0, 1, 0, 32'h0, 32'hFFFFFFFF), 0, 0);
    step(0, '0, 0, 5);
    chk("r0_cnt", retired_count, c0 + 32'd1);

    // branch shadow drops r1/r2, r3 retires
    c0 = m_cnt;
    step(1, mk(1, 0, 0, 32'h40, 32'h0), 1, 2);
    chk("br_pc", redirect_pc, 32'h40);
    step(1, mk(0, 1, 1, 32'h0, 32'h11), 1, 2);
    step(1, mk(0, 1, 2, 32'h0, 32'h22), 1, 2);
    step(1, mk(0, 1, 3, 32'h0, 32'h33), 3, 1);
    step(0, '0, 2, 3);
    chk("br_r3", rd_data_b, 32'h33);
    chk("br_cnt", retired_count, c0 + 32'd2);

    // stall inside flush with write-enable noise
    step(1, mk(1, 0, 0, 32'h80, 32'h0), 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, mk(0, 1, 9, 32'h0, 32'hDEAD0000 + i), 9, 9);
    step(1, mk(0, 1, 9, 32'h0, 32'h99), 9, 0);
    step(1, mk(0, 1, 10, 32'h0, 32'hAA), 10, 9);
    step(1, mk(0, 1, 11, 32'h0, 32'hBB), 11, 10);

    // async reset one cycle after a branch
    step(1, mk(1, 1, 4, 32'hC0, 32'h44), 4, 0);
    step(0, '0, 3, 4);
    @(negedge clock);
    ex_wb_valid = 1'b0;
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd4;
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    check_outs();
    chk("rst_rd_a", rd_data_a, 32'd0);
    chk("rst_rd_b", rd_data_b, 32'd0);
    ex_wb = mk(1, 1, 6, 32'h100, 32'h66);
    ex_wb_valid = 1'b1;
    @(posedge clock);
    #1;
    check_outs();
    @(negedge clock);
    ex_wb_valid = 1'b0;
    reset_n = 1'b1;
    step(1, mk(0, 1, 6, 32'h0, 32'h600D), 6, 3);
    step(0, '0, 6, 4);

    // retire counter wrap
    @(negedge clock);
    ex_wb_valid = 1'b0;
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    m_cnt = 32'hFFFFFFFF;
    step(1, mk(0, 1, 12, 32'h0, 32'hC), 12, 0);
    chk("wrap_cnt", retired_count, 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rw = mk(($urandom_range(0, 7) == 0), 1'($urandom),
              5'($urandom), $urandom, $urandom);
      ra = ($urandom_range(0, 1) == 1) ? rw[68:64] : 5'($urandom);
      rb = 5'($urandom);
      step(($urandom_range(0, 3) != 0), rw, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of consumed words discarded after a taken branch (legal range 1..7).
REQ-002 Parameter NUM_REGS, default 32, register file depth, addressed by 5 bits.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 ex_wb  input  71  execute-stage word: [31:0] result, [63:32] PC/branch target, [68:64] destination register, [69] register write enable, [70] branch taken.
REQ-006 ex_wb_valid  input  1  ex_wb holds a new word this cycle; word is consumed only when high.
REQ-007 rd_addr_a  input  5  decode read port A address.
REQ-008 rd_addr_b  input  5  decode read port B address.
REQ-009 rd_data_a  output  32  combinational read data, port A.
REQ-010 rd_data_b  output  32  combinational read data, port B.
REQ-011 redirect_valid  output  1  registered one-cycle pulse: fetch loads redirect_pc.
REQ-012 redirect_pc  output  32  registered branch target.
REQ-013 flushing  output  1  high while the block is in FLUSH.
REQ-014 retired_count  output  32  registered count of retired words.

Function
REQ-015 The block SHALL have two states: RUN and FLUSH.
REQ-016 In RUN, a consumed word (ex_wb_valid=1) SHALL retire: retired_count increments by 1, wrapping 0xFFFFFFFF -> 0.
REQ-017 A retiring word with bit 69 set SHALL write bits [31:0] into register [68:64] at that rising edge.
REQ-018 Writes to register 0 SHALL be ignored, and reads of register 0 SHALL return 0.
REQ-019 A retiring word with bit 70 set SHALL cause, at that edge, redirect_valid<=1, redirect_pc<=ex_wb[63:32], state->FLUSH, flush counter<=FLUSH_CYCLES.
REQ-020 A retiring word with bits 69 and 70 both set SHALL perform both the write and the redirect.
REQ-021 redirect_valid SHALL be high for exactly one cycle per taken branch.
REQ-022 redirect_pc SHALL hold its value until the next taken branch.
REQ-023 In FLUSH, each consumed word SHALL be discarded: no register write, no redirect, no count increment, and the flush counter decrements by 1.
REQ-024 The transition FLUSH->RUN SHALL occur at the edge on which the counter goes 1->0; the next consumed word retires normally.
REQ-025 In FLUSH with ex_wb_valid=0, the counter SHALL hold.
REQ-026 In any state with ex_wb_valid=0, no register write, redirect or count change SHALL occur, regardless of ex_wb contents.
REQ-027 Read ports SHALL bypass writes: if a port address equals the address of a write occurring at the coming edge, and that address is nonzero, the port SHALL return ex_wb[31:0] in the same cycle.
REQ-028 Otherwise, a written value SHALL be visible on the read ports from the cycle after the write edge.
REQ-029 flushing SHALL equal (state==FLUSH).

Reset
REQ-030 Assertion of reset_n=0 SHALL immediately force the following, independent of clock: state RUN, flush counter 0, redirect_valid 0, redirect_pc 0, retired_count 0, all registers 0.
REQ-031 Reset during FLUSH SHALL abandon the flush; the first consumed word after release retires normally.
REQ-032 Words presented while reset_n=0 SHALL be ignored.

Structure
REQ-033 Field bit positions of ex_wb, the state encoding, and the default FLUSH_CYCLES SHALL live in a shared pipeline package, also used by execute.
REQ-034 The register file (two async read ports, one sync write port, r0 tie-off, bypass) SHALL be a sub-module named regfile_2r1w.

Verification
REQ-035 Scenario write/read: consume a word with write enable, result 0x0000ABCD, dest 5 -> port A reading r5 shows 0x0000ABCD in the same cycle (bypass) and on all later cycles.
REQ-036 Scenario r0 protection: consume a word writing 0xFFFFFFFF to r0 -> r0 reads 0; retired_count still increments by 1.
REQ-037 Scenario branch flush: consume a taken branch with target 0x00000040, then 3 write words to r1/r2/r3 -> redirect_valid pulses once with redirect_pc=0x40; r1 and r2 stay 0; r3 is written; retired_count increases by 2.
REQ-038 Scenario stall during flush: consume a taken branch, hold ex_wb_valid=0 for 4 cycles with write enable set -> flushing stays high, no registers change; the next 2 valid words are discarded.
REQ-039 Scenario reset mid-flush: drop reset_n asynchronously one cycle after a branch -> all outputs are 0 immediately; after release, the first write word retires.
REQ-040 Scenario counter wrap: preload retired_count by forcing it to 0xFFFFFFFF, then retire 1 word -> retired_count = 0.
